// File: rtl/mem_ctrl.sv
// Memory access sequencer: turns single-cycle mem_rd/mem_wr strobes into a
// req/ack transaction on a variable-latency bus, with a posted write buffer and timeout.
module mem_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              stall,
    output logic              bus_err,
    output logic              ext_req,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_ack,
    input  logic [DATA_W-1:0] ext_rdata
);

    localparam logic [7:0] TO_LOAD = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RD_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_bus_err;

    logic w_rd_req;
    logic w_wr_req;
    logic w_both;
    logic w_waiting;
    logic w_expire;
    logic w_accept;
    logic w_stall;

    assign w_rd_req  = mem_rd & ~mem_wr;
    assign w_wr_req  = mem_wr & ~mem_rd;
    assign w_both    = mem_rd & mem_wr;
    assign w_waiting = (r_state == RD_WAIT) || (r_state == WR_WAIT);
    // Last permitted wait cycle with no ack: abort. An ack in this cycle still wins.
    assign w_expire  = w_waiting && !ext_ack && (r_cnt == 8'd1);
    assign w_accept  = (r_state == IDLE) && (w_rd_req || w_wr_req);

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall = w_rd_req;
                if (w_rd_req)
                    w_next = RD_WAIT;
                else if (w_wr_req)
                    w_next = WR_WAIT;
            end
            RD_WAIT: begin
                w_stall = 1'b1;
                if (ext_ack || w_expire)
                    w_next = RD_DONE;
            end
            WR_WAIT: begin
                // Write buffer occupied: any new access waits for the bus to free up.
                w_stall = w_rd_req | w_wr_req;
                if (ext_ack || w_expire)
                    w_next = IDLE;
            end
            RD_DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= 8'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_bus_err <= w_expire || ((r_state == IDLE) && w_both);
            if (w_accept) begin
                r_addr <= addr;
                r_cnt  <= TO_LOAD;
                if (w_wr_req)
                    r_wdata <= wdata;
            end else if (w_waiting && !ext_ack) begin
                r_cnt <= r_cnt - 8'd1;
            end
            // A timed-out read returns zero so the control unit can unblock.
            if (r_state == RD_WAIT) begin
                if (ext_ack)
                    r_rdata <= ext_rdata;
                else if (w_expire)
                    r_rdata <= '0;
            end
        end
    end

    assign ext_req   = w_waiting;
    assign ext_we    = (r_state == WR_WAIT);
    assign ext_addr  = r_addr;
    assign ext_wdata = r_wdata;
    assign rdata     = r_rdata;
    assign rd_valid  = (r_state == RD_DONE);
    assign bus_err   = r_bus_err;
    assign stall     = rst & w_stall;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: transaction-level model predicts every cycle's outputs,
// a compare process checks them, directed tests pin literal values.
module tb_mem_ctrl;

    localparam int TO = 5;

    logic        clk;
    logic        rst;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rd_valid;
    logic        stall;
    logic        bus_err;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_ack;
    logic [31:0] ext_rdata;

    mem_ctrl #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid),
        .stall(stall), .bus_err(bus_err), .ext_req(ext_req), .ext_we(ext_we),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_ack(ext_ack),
        .ext_rdata(ext_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        req;
        logic        we;
        logic        rdv;
        logic        err;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    exp_t ce;

    int n_chk = 0;
    int n_err = 0;

    // model state
    logic        wbusy = 1'b0;
    logic [15:0] wa;
    logic [31:0] wd;
    int          wdly;
    int          wk;
    logic        pend_err = 1'b0;
    logic [31:0] exp_rdata = '0;

    // tallies for directed literal checks
    int          n_req, n_stall, n_we, n_errp, n_ovl, cyc, rdv_at;
    logic [31:0] last_rd;
    logic        prev_req, prev_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            ce = exp_q.pop_front();
            chk("stall",    32'(stall),    32'(ce.stall));
            chk("ext_req",  32'(ext_req),  32'(ce.req));
            chk("ext_we",   32'(ext_we),   32'(ce.we));
            chk("rd_valid", 32'(rd_valid), 32'(ce.rdv));
            chk("bus_err",  32'(bus_err),  32'(ce.err));
            chk("rdata",    rdata,         ce.rd);
            if (ce.req)
                chk("ext_addr", 32'(ext_addr), 32'(ce.a));
            if (ce.req && ce.we)
                chk("ext_wdata", ext_wdata, ce.d);
        end
    end

    task automatic clr();
        n_req = 0; n_stall = 0; n_we = 0; n_errp = 0; n_ovl = 0;
        cyc = 0; rdv_at = -1; last_rd = 32'hDEAD_DEAD;
        prev_req = 1'b0; prev_we = 1'b0;
    endtask

    // One clock cycle: queue the expectation, let the compare run, tally, advance.
    task automatic push(input exp_t e_in, input logic err_next);
        exp_t e;
        e = e_in;
        e.err = pend_err;
        pend_err = err_next;
        e.rd = exp_rdata;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        if (ext_req) n_req++;
        if (stall) n_stall++;
        if (ext_req && ext_we) n_we++;
        if (bus_err) n_errp++;
        if (prev_req && ext_req && (prev_we != ext_we)) n_ovl++;
        if (rd_valid) begin
            rdv_at = cyc;
            last_rd = rdata;
        end
        prev_req = ext_req;
        prev_we = ext_we;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic write_beat(input logic held, output exp_t e, output logic err_next);
        wk++;
        e = '0;
        e.stall = held; e.req = 1'b1; e.we = 1'b1; e.a = wa; e.d = wd;
        ext_ack = (wk == wdly);
        ext_rdata = $urandom;
        err_next = 1'b0;
        if (wk == wdly)
            wbusy = 1'b0;
        else if (wk == TO) begin
            wbusy = 1'b0;
            err_next = 1'b1;
        end
    endtask

    task automatic tick_idle();
        exp_t e;
        logic en;
        mem_rd = 1'b0; mem_wr = 1'b0;
        addr = 16'($urandom); wdata = $urandom;
        if (wbusy) begin
            write_beat(1'b0, e, en);
            push(e, en);
        end else begin
            e = '0;
            ext_ack = 1'($urandom_range(0, 1));
            ext_rdata = $urandom;
            push(e, 1'b0);
        end
    endtask

    task automatic drain_wr(); // hold current request while the posted write finishes
        exp_t e;
        logic en;
        while (wbusy) begin
            write_beat(1'b1, e, en);
            push(e, en);
        end
    endtask

    task automatic op_write(input logic [15:0] a, input logic [31:0] d, input int dly);
        exp_t e;
        mem_rd = 1'b0; mem_wr = 1'b1; addr = a; wdata = d;
        drain_wr();
        e = '0;
        ext_ack = 1'($urandom_range(0, 1));
        ext_rdata = $urandom;
        push(e, 1'b0);
        wbusy = 1'b1; wk = 0; wa = a; wd = d; wdly = dly;
        mem_wr = 1'b0; addr = 16'($urandom); wdata = $urandom;
    endtask

    task automatic op_read(input logic [15:0] a, input logic [31:0] val, input int dly);
        exp_t e;
        logic ack, tmo;
        mem_rd = 1'b1; mem_wr = 1'b0; addr = a; wdata = $urandom;
        drain_wr();
        e = '0; e.stall = 1'b1;
        ext_ack = 1'($urandom_range(0, 1));
        ext_rdata = $urandom;
        push(e, 1'b0);
        for (int k = 1; k <= TO; k++) begin
            ack = (k == dly);
            tmo = !ack && (k == TO);
            e = '0; e.stall = 1'b1; e.req = 1'b1; e.a = a;
            ext_ack = ack;
            ext_rdata = ack ? val : $urandom;
            push(e, tmo);
            if (ack) begin
                exp_rdata = val;
                break;
            end
            if (tmo) exp_rdata = '0;
        end
        e = '0; e.rdv = 1'b1;
        ext_ack = 1'($urandom_range(0, 1));
        ext_rdata = $urandom;
        push(e, 1'b0);
        mem_rd = 1'b0;
    endtask

    task automatic op_both();
        exp_t e;
        while (wbusy) tick_idle();
        mem_rd = 1'b1; mem_wr = 1'b1; addr = 16'($urandom); wdata = $urandom;
        e = '0;
        ext_ack = 1'b0;
        push(e, 1'b1);
        mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; wdata = '0;
        ext_ack = 1'b0; ext_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ext_req", 32'(ext_req), 0);
        chk("reset_stall", 32'(stall), 0);
        chk("reset_rd_valid", 32'(rd_valid), 0);
        chk("reset_bus_err", 32'(bus_err), 0);
        chk("reset_ext_we", 32'(ext_we), 0);
        chk("reset_ext_addr", 32'(ext_addr), 0);
        chk("reset_ext_wdata", ext_wdata, 0);
        chk("reset_rdata", rdata, 0);
        rst = 1'b1;
        tick_idle(); tick_idle();

        // posted write, ack in 3rd wait cycle
        clr();
        op_write(16'h0010, 32'hCAFE_F00D, 3);
        repeat (5) tick_idle();
        chk("t1_req_cycles", 32'(n_req), 3);
        chk("t1_we_cycles", 32'(n_we), 3);
        chk("t1_stall_cycles", 32'(n_stall), 0);

        // read acked in first wait cycle
        clr();
        op_read(16'h0020, 32'h1234_5678, 1);
        chk("t2_stall_cycles", 32'(n_stall), 2);
        chk("t2_rdv_cycle", 32'(rdv_at), 2);
        chk("t2_rdata", last_rd, 32'h1234_5678);
        tick_idle();

        // write with ack on the last allowed cycle, read to same address right behind it
        clr();
        op_write(16'h0030, 32'h0BAD_F00D, 5);
        op_read(16'h0030, 32'h3030_3030, 2);
        chk("t3_stall_cycles", 32'(n_stall), 8);
        chk("t3_rdv_cycle", 32'(rdv_at), 9);
        chk("t3_req_cycles", 32'(n_req), 7);
        chk("t3_overlap", 32'(n_ovl), 0);
        chk("t3_bus_err", 32'(n_errp), 0);
        chk("t3_rdata", last_rd, 32'h3030_3030);
        tick_idle();

        // read never acked
        clr();
        op_read(16'h0044, 32'h7777_7777, 100);
        chk("t4_req_cycles", 32'(n_req), TO);
        chk("t4_bus_err", 32'(n_errp), 1);
        chk("t4_rdv_cycle", 32'(rdv_at), 6);
        chk("t4_rdata", last_rd, 0);
        tick_idle();

        // both strobes at once
        clr();
        op_both();
        tick_idle(); tick_idle();
        chk("t5_bus_err", 32'(n_errp), 1);
        chk("t5_req_cycles", 32'(n_req), 0);
        chk("t5_stall_cycles", 32'(n_stall), 0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2)
                repeat ($urandom_range(1, 3)) tick_idle();
            else if (r < 6)
                op_write(16'($urandom), $urandom, $urandom_range(1, TO + 2));
            else if (r < 9)
                op_read(16'($urandom), $urandom, $urandom_range(1, TO + 2));
            else
                op_both();
        end
        while (wbusy) tick_idle();
        tick_idle(); tick_idle();

        // asynchronous reset in the middle of a read wait
        op_read(16'h0048, 32'hA5A5_5A5A, 1);
        tick_idle();
        begin
            exp_t e;
            mem_rd = 1'b1; mem_wr = 1'b0; addr = 16'h0050;
            e = '0; e.stall = 1'b1; ext_ack = 1'b0;
            push(e, 1'b0);
            e = '0; e.stall = 1'b1; e.req = 1'b1; e.a = 16'h0050; ext_ack = 1'b0;
            push(e, 1'b0);
        end
        #2 rst = 1'b0;
        #1;
        chk("t6_ext_req", 32'(ext_req), 0);
        chk("t6_stall", 32'(stall), 0);
        chk("t6_rd_valid", 32'(rd_valid), 0);
        chk("t6_bus_err", 32'(bus_err), 0);
        chk("t6_rdata", rdata, 0);
        chk("t6_ext_addr", 32'(ext_addr), 0);
        mem_rd = 1'b0;
        exp_rdata = '0; wbusy = 1'b0; pend_err = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b1;
        tick_idle();
        clr();
        op_read(16'h0040, 32'h4040_BEEF, 1);
        chk("t6_read_rdata", last_rd, 32'h4040_BEEF);
        chk("t6_read_rdv_cycle", 32'(rdv_at), 2);
        tick_idle(); tick_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
